// File: rtl/cmos_cap_pkg.sv
// Shared types and constants for the camera capture front end.
package cmos_cap_pkg;

    typedef enum logic [1:0] {
        WAIT_INIT,
        SKIP,
        ARM,
        FRAME
    } cap_state_e;

    localparam int PIX_W         = 16;
    localparam int BYTE_HI_FIRST = 0;
    localparam int BYTE_LO_FIRST = 1;

endpackage

// File: rtl/cmos_fps_meter.sv
// Counts events over a free-running 1 s gate and publishes the count, saturating at 255.
module cmos_fps_meter #(
    parameter int CLK_HZ = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       event_in,
    output logic [7:0] fps
);

    localparam int GW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(CLK_HZ - 1);

    logic [GW-1:0] gate_q, gate_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    fps_q, fps_d;
    logic          wrap;

    always_comb begin
        wrap   = (gate_q == GATE_LAST);
        gate_d = wrap ? '0 : gate_q + 1'b1;
        fps_d  = fps_q;
        if (wrap) begin
            // The count itself saturates, so publishing it is already min(count, 255).
            fps_d = cnt_q;
            cnt_d = {7'd0, event_in};
        end else if (event_in && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // NOTE: state registers take non-blocking assignments only, so every flop samples
    // the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q <= '0;
            cnt_q  <= '0;
            fps_q  <= '0;
        end else begin
            gate_q <= gate_d;
            cnt_q  <= cnt_d;
            fps_q  <= fps_d;
        end
    end

    assign fps = fps_q;

endmodule

// File: rtl/cmos_frame_capture.sv
// Camera capture front end: byte pairing, settle skip, crop window, decimation,
// frame-integrity checking and fps measurement feeding the frame-buffer write FIFO.
module cmos_frame_capture
    import cmos_cap_pkg::*;
#(
    parameter int CLK_HZ      = 25_000_000,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 10,
    parameter int BYTE_ORDER  = 0,
    parameter int X_W         = 11,
    parameter int Y_W         = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_done,
    input  logic             cmos_vsync,
    input  logic             cmos_href,
    input  logic [7:0]       cmos_data,
    input  logic [X_W-1:0]   win_x0,
    input  logic [Y_W-1:0]   win_y0,
    input  logic [X_W-1:0]   win_w,
    input  logic [Y_W-1:0]   win_h,
    input  logic [3:0]       decim,
    output logic             pix_we,
    output logic [PIX_W-1:0] pix_data,
    output logic             frame_valid,
    output logic             frame_start,
    output logic [7:0]       fps,
    output logic             frame_err
);

    localparam int SK_W = $clog2(SKIP_FRAMES + 2);
    localparam logic [SK_W-1:0] SKIP_N = SK_W'(SKIP_FRAMES);
    localparam logic [X_W-1:0]  H_N    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]  V_N    = Y_W'(V_ACTIVE);

    logic             vsync_q, vsync_qq, href_q, href_qq;
    logic [7:0]       data_q;
    cap_state_e       state_q, state_d;
    logic [SK_W-1:0]  skip_q, skip_d;
    logic [3:0]       dec_q, dec_d;
    logic             phase_q, phase_d;
    logic [7:0]       byte_q, byte_d;
    logic [X_W-1:0]   x_q, x_d, x0_q, x0_d, w_q, w_d;
    logic [Y_W-1:0]   y_q, y_d, y0_q, y0_d, h_q, h_d;
    logic [PIX_W-1:0] asm_q, asm_d, pix_data_q, pix_data_d;
    logic             hit_q, hit_d, pix_we_q, pix_we_d;
    logic             frame_valid_q, frame_valid_d, frame_start_q, frame_start_d;
    logic             err_q, err_d;

    logic             vsync_rise, href_fall, pixel_done, in_frame, frame_begin, x_in, y_in;
    logic [Y_W-1:0]   y_closed;

    always_comb begin
        vsync_rise  = vsync_q & ~vsync_qq;
        href_fall   = ~href_q & href_qq;
        pixel_done  = href_q & phase_q;
        in_frame    = (state_q == FRAME);
        frame_begin = init_done && vsync_rise && (state_q == ARM || state_q == FRAME);
        // A line closing on the same cycle as vsync counts toward the frame it ends.
        y_closed    = href_fall ? y_q + 1'b1 : y_q;
        x_in = (x_q >= x0_q) && ({1'b0, x_q} < ({1'b0, x0_q} + {1'b0, w_q})) && (x_q < H_N);
        y_in = (y_q >= y0_q) && ({1'b0, y_q} < ({1'b0, y0_q} + {1'b0, h_q})) && (y_q < V_N);

        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        skip_d        = skip_q;
        dec_d         = dec_q;
        x0_d          = x0_q;
        y0_d          = y0_q;
        w_d           = w_q;
        h_d           = h_q;
        byte_d        = byte_q;
        asm_d         = asm_q;
        x_d           = x_q;
        y_d           = y_q;
        err_d         = err_q;
        frame_valid_d = frame_valid_q;
        frame_start_d = 1'b0;
        pix_data_d    = pix_data_q;
        phase_d       = init_done & href_q & ~phase_q;

        case (state_q)
            WAIT_INIT: if (init_done) begin
                state_d = SKIP;
                skip_d  = '0;
            end
            SKIP: begin
                if (skip_q >= SKIP_N)  state_d = ARM;
                else if (vsync_rise)   skip_d  = skip_q + 1'b1;
            end
            ARM:     if (vsync_rise) state_d = FRAME;
            FRAME:   ;
            default: state_d = WAIT_INIT;
        endcase

        if (href_q && !phase_q) byte_d = data_q;
        if (pixel_done) begin
            asm_d = (BYTE_ORDER == BYTE_LO_FIRST) ? {data_q, byte_q} : {byte_q, data_q};
            x_d   = x_q + 1'b1;
        end
        hit_d = pixel_done && frame_valid_q && x_in && y_in && init_done;

        if (href_fall) begin
            x_d = '0;
            y_d = y_closed;
            if (in_frame && (x_q != H_N || phase_q)) err_d = 1'b1;
        end

        if (frame_begin) begin
            if (in_frame && y_closed != V_N) err_d = 1'b1;
            x0_d          = win_x0;
            y0_d          = win_y0;
            w_d           = win_w;
            h_d           = win_h;
            y_d           = '0;
            dec_d         = (dec_q >= decim) ? 4'd0 : dec_q + 1'b1;
            frame_valid_d = (dec_q == 4'd0);
            frame_start_d = (dec_q == 4'd0);
        end

        pix_we_d = hit_q && init_done;
        if (hit_q) pix_data_d = asm_q;

        if (!init_done) begin
            state_d       = WAIT_INIT;
            dec_d         = '0;
            frame_valid_d = 1'b0;
            frame_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q       <= 1'b0;
            vsync_qq      <= 1'b0;
            href_q        <= 1'b0;
            href_qq       <= 1'b0;
            data_q        <= '0;
            state_q       <= WAIT_INIT;
            skip_q        <= '0;
            dec_q         <= '0;
            phase_q       <= 1'b0;
            byte_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            x0_q          <= '0;
            y0_q          <= '0;
            w_q           <= '0;
            h_q           <= '0;
            asm_q         <= '0;
            hit_q         <= 1'b0;
            pix_we_q      <= 1'b0;
            pix_data_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            vsync_q       <= cmos_vsync;
            vsync_qq      <= vsync_q;
            href_q        <= cmos_href;
            href_qq       <= href_q;
            data_q        <= cmos_data;
            state_q       <= state_d;
            skip_q        <= skip_d;
            dec_q         <= dec_d;
            phase_q       <= phase_d;
            byte_q        <= byte_d;
            x_q           <= x_d;
            y_q           <= y_d;
            x0_q          <= x0_d;
            y0_q          <= y0_d;
            w_q           <= w_d;
            h_q           <= h_d;
            asm_q         <= asm_d;
            hit_q         <= hit_d;
            pix_we_q      <= pix_we_d;
            pix_data_q    <= pix_data_d;
            frame_valid_q <= frame_valid_d;
            frame_start_q <= frame_start_d;
            err_q         <= err_d;
        end
    end

    cmos_fps_meter #(.CLK_HZ(CLK_HZ)) u_fps (
        .clk      (clk),
        .rst_n    (rst_n),
        .event_in (vsync_rise && state_q != WAIT_INIT),
        .fps      (fps)
    );

    assign pix_we      = pix_we_q;
    assign pix_data    = pix_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_start = frame_start_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_cmos_frame_capture.sv
// Directed bench for cmos_frame_capture on a reduced 16x8 frame, two byte orders side by side.
module tb_cmos_frame_capture;

    localparam int H = 16;
    localparam int V = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic        cmos_vsync = 1'b0;
    logic        cmos_href = 1'b0;
    logic [7:0]  cmos_data = '0;
    logic [10:0] win_x0, win_w;
    logic [9:0]  win_y0, win_h;
    logic [3:0]  decim;

    logic        pix_we0, frame_valid0, frame_start0, frame_err0;
    logic [15:0] pix_data0;
    logic [7:0]  fps0;
    logic        pix_we1, frame_valid1, frame_start1, frame_err1;
    logic [15:0] pix_data1;
    logic [7:0]  fps1;

    always #5 clk = ~clk;

    cmos_frame_capture #(
        .CLK_HZ(1000), .H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(2),
        .BYTE_ORDER(0), .X_W(11), .Y_W(10)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
        .win_x0(win_x0), .win_y0(win_y0), .win_w(win_w), .win_h(win_h), .decim(decim),
        .pix_we(pix_we0), .pix_data(pix_data0), .frame_valid(frame_valid0),
        .frame_start(frame_start0), .fps(fps0), .frame_err(frame_err0)
    );

    cmos_frame_capture #(
        .CLK_HZ(1000), .H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(2),
        .BYTE_ORDER(1), .X_W(11), .Y_W(10)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
        .win_x0(win_x0), .win_y0(win_y0), .win_w(win_w), .win_h(win_h), .decim(decim),
        .pix_we(pix_we1), .pix_data(pix_data1), .frame_valid(frame_valid1),
        .frame_start(frame_start1), .fps(fps1), .frame_err(frame_err1)
    );

    int checks = 0;
    int errors = 0;
    int pix_cnt = 0;
    int start_cnt = 0;
    bit lat_chk = 1'b0;
    bit drop_chk = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 2 time units after the active edge.
    always @(posedge clk) begin
        #2;
        if (pix_we0) pix_cnt++;
        if (frame_start0) start_cnt++;
    end

    task automatic send_line(input int nbytes, input int line);
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            cmos_href = 1'b1;
            cmos_data = (i == 0) ? 8'hAB : (i == 1) ? 8'hCD : 8'(i * 3 + line * 17);
            if (lat_chk && line == 0 && i == 1) begin
                fork
                    begin
                        @(posedge clk);
                        @(posedge clk);
                        #1 check("pix_we_one_clk", 32'(pix_we0), 32'd0);
                        @(posedge clk);
                        #1 check("pix_we_two_clk", 32'(pix_we0), 32'd1);
                        check("pix_data_order0", 32'(pix_data0), 32'h0000ABCD);
                        check("pix_data_order1", 32'(pix_data1), 32'h0000CDAB);
                    end
                join_none
            end
            if (drop_chk && line == 0 && i == 10) begin
                init_done = 1'b0;
                fork
                    begin
                        @(posedge clk);
                        #1 check("frame_valid_after_drop", 32'(frame_valid0), 32'd0);
                    end
                join_none
            end
        end
        @(negedge clk);
        cmos_href = 1'b0;
        cmos_data = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input int nlines, input int bad_line, input int bad_bytes,
                              input bit mid_change, output int npix);
        int base;
        @(negedge clk);
        base = pix_cnt;
        cmos_vsync = 1'b1;
        repeat (2) @(negedge clk);
        cmos_vsync = 1'b0;
        repeat (3) @(negedge clk);
        for (int l = 0; l < nlines; l++) begin
            send_line((l == bad_line) ? bad_bytes : 2 * H, l);
            if (mid_change && l == 0) begin
                win_x0 = '0; win_w = 11'(H); win_y0 = '0; win_h = 10'(V);
            end
        end
        repeat (4) @(negedge clk);
        npix = pix_cnt - base;
    endtask

    task automatic bring_up();
        int n;
        @(negedge clk);
        rst_n = 1'b0;
        init_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        init_done = 1'b1;
        send_frame(V, -1, 0, 1'b0, n);
        send_frame(V, -1, 0, 1'b0, n);
    endtask

    initial begin
        int n;
        int s0;
        win_x0 = '0; win_w = 11'(H); win_y0 = '0; win_h = 10'(V); decim = '0;
        repeat (3) @(negedge clk);
        check("rst_pix_we", 32'(pix_we0), 32'd0);
        check("rst_pix_data", 32'(pix_data0), 32'd0);
        check("rst_frame_valid", 32'(frame_valid0), 32'd0);
        check("rst_frame_start", 32'(frame_start0), 32'd0);
        check("rst_fps", 32'(fps0), 32'd0);
        check("rst_frame_err", 32'(frame_err0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        init_done = 1'b1;

        // Two settle frames, then capture starts on the third vsync.
        send_frame(V, -1, 0, 1'b0, n);
        check("skip1_pix", n, 0);
        check("skip1_fv", 32'(frame_valid0), 32'd0);
        send_frame(V, -1, 0, 1'b0, n);
        check("skip2_pix", n, 0);
        check("skip2_fv", 32'(frame_valid0), 32'd0);
        lat_chk = 1'b1;
        send_frame(V, -1, 0, 1'b0, n);
        lat_chk = 1'b0;
        check("cap1_pix", n, H * V);
        check("cap1_fv", 32'(frame_valid0), 32'd1);
        check("cap1_starts", start_cnt, 1);
        send_frame(V, -1, 0, 1'b0, n);
        check("cap2_pix", n, H * V);

        // Window clipped on both axes: columns 12..15, rows 6..7.
        win_x0 = 11'd12; win_w = 11'd8; win_y0 = 10'd6; win_h = 10'd5;
        send_frame(V, -1, 0, 1'b0, n);
        check("win_clip_pix", n, 8);
        send_frame(V, -1, 0, 1'b1, n);
        check("win_midframe_pix", n, 8);
        send_frame(V, -1, 0, 1'b0, n);
        check("win_next_full_pix", n, H * V);
        win_w = '0;
        send_frame(V, -1, 0, 1'b0, n);
        check("win_w0_pix", n, 0);
        check("win_w0_fv", 32'(frame_valid0), 32'd1);
        win_w = 11'(H);
        send_frame(V, -1, 0, 1'b0, n);
        check("full_again_pix", n, H * V);
        check("good_frames_err", 32'(frame_err0), 32'd0);

        // decim = 2: frames 0 and 3 of six are captured.
        decim = 4'd2;
        s0 = start_cnt;
        for (int i = 0; i < 6; i++) begin
            send_frame(V, -1, 0, 1'b0, n);
            check($sformatf("decim_f%0d_pix", i), n, (i % 3 == 0) ? H * V : 0);
        end
        check("decim_starts", start_cnt - s0, 2);
        decim = '0;

        // Short line (15 px) sets a sticky error.
        send_frame(V, 1, 2 * H - 2, 1'b0, n);
        check("short_line_err", 32'(frame_err0), 32'd1);
        send_frame(V, -1, 0, 1'b0, n);
        send_frame(V, -1, 0, 1'b0, n);
        check("err_sticky", 32'(frame_err0), 32'd1);

        // Odd byte count with the right pixel count: phase alone flags it.
        bring_up();
        check("err_cleared_by_reset", 32'(frame_err0), 32'd0);
        send_frame(V, 3, 2 * H + 1, 1'b0, n);
        check("odd_byte_err", 32'(frame_err0), 32'd1);

        // Frame of 7 lines is flagged when the next vsync closes it.
        bring_up();
        send_frame(V - 1, -1, 0, 1'b0, n);
        check("short_frame_err_pending", 32'(frame_err0), 32'd0);
        send_frame(V, -1, 0, 1'b0, n);
        check("short_frame_err", 32'(frame_err0), 32'd1);

        // init_done dropped after 10 bytes of line 0: only 4 pixels leave.
        drop_chk = 1'b1;
        send_frame(V, -1, 0, 1'b0, n);
        drop_chk = 1'b0;
        check("drop_pix", n, 4);

        // fps: vsync every 100 clk on a 1000 clk gate.
        init_done = 1'b1;
        repeat (25) begin
            @(negedge clk);
            cmos_vsync = 1'b1;
            repeat (50) @(negedge clk);
            cmos_vsync = 1'b0;
            repeat (49) @(negedge clk);
        end
        check("fps_10", 32'(fps0), 32'd10);
        repeat (2200) begin
            @(negedge clk);
            cmos_vsync = ~cmos_vsync;
        end
        check("fps_saturate", 32'(fps0), 32'd255);
        init_done = 1'b0;
        repeat (2200) begin
            @(negedge clk);
            cmos_vsync = ~cmos_vsync;
        end
        check("fps_wait_init", 32'(fps0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
